// File: rtl/fifo_wr_stage_if.sv
// fifo_wr_stage_if: producer handshake, FIFO write port and status bundle for fifo_wr_stage
interface fifo_wr_stage_if #(
   parameter int DataWidth = 8,
   parameter int CountWidth = 16
);
   logic                  s_valid;
   logic [DataWidth-1:0]  s_data;
   logic                  s_ready;
   logic                  full;
   logic                  wr_en;
   logic [DataWidth-1:0]  din;
   logic [CountWidth-1:0] wr_count;
   logic                  stall;
   modport master (output s_valid, s_data, full, input s_ready, wr_en, din, wr_count, stall);
   modport slave (input s_valid, s_data, full, output s_ready, wr_en, din, wr_count, stall);
endinterface

// File: rtl/fifo_wr_stage.sv
// fifo_wr_stage: two-entry skid front end feeding a FIFO write port, with write counter and stall flag
module fifo_wr_stage #(
   parameter int DataWidth = 8,
   parameter int CountWidth = 16
) (
   input logic wr_clk,
   input logic rst_n,
   fifo_wr_stage_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state_q, state_d;
   logic [DataWidth-1:0] main_data, skid_data;
   logic [CountWidth-1:0] count;
   logic s_ready_q, main_valid, accept, write, load_main, load_skid, from_skid;
   assign main_valid = state_q != EMPTY;
   assign accept = bus.s_valid && s_ready_q;
   assign write = main_valid && !bus.full;
   always_comb begin
      state_d = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            state_d = accept ? ONE : EMPTY;
            load_main = accept;
         end
         ONE: begin
            state_d = write ? (accept ? ONE : EMPTY) : (accept ? TWO : ONE);
            load_main = write && accept;
            load_skid = !write && accept;
         end
         TWO: begin
            state_d = write ? ONE : TWO;
            from_skid = write;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_data <= '0;
         skid_data <= '0;
         s_ready_q <= 1'b0;
         count <= '0;
      end else begin
         state_q <= state_d;
         if (load_main) main_data <= bus.s_data;
         else if (from_skid) main_data <= skid_data;
         if (load_skid) skid_data <= bus.s_data;
         // ready is the complement of next-cycle skid occupancy, so it never depends on s_valid
         s_ready_q <= state_d != TWO;
         if (write) count <= count + CountWidth'(1);
      end
   end
   assign bus.s_ready = s_ready_q;
   assign bus.wr_en = write;
   assign bus.din = main_data;
   assign bus.stall = main_valid && bus.full;
   assign bus.wr_count = count;
endmodule

// File: tb/tb_fifo_wr_stage.sv
// tb_fifo_wr_stage: queue-model scoreboard plus directed and random stimulus for fifo_wr_stage
module tb_fifo_wr_stage;
   logic wr_clk = 1'b0;
   logic rst_n;
   int tests = 0;
   int fails = 0;
   logic [7:0] pend[$];
   bit ready_ok = 1'b0;
   int cnt = 0;
   fifo_wr_stage_if #(.DataWidth(8), .CountWidth(16)) bus ();
   fifo_wr_stage_if #(.DataWidth(8), .CountWidth(4)) bus4 ();
   fifo_wr_stage #(.DataWidth(8), .CountWidth(16)) dut (.wr_clk(wr_clk), .rst_n(rst_n), .bus(bus.slave));
   fifo_wr_stage #(.DataWidth(8), .CountWidth(4)) dut4 (.wr_clk(wr_clk), .rst_n(rst_n), .bus(bus4.slave));
   assign bus4.s_valid = bus.s_valid;
   assign bus4.s_data = bus.s_data;
   assign bus4.full = bus.full;
   always #5 wr_clk = ~wr_clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Inputs change only just after rising edges, so at the falling edge they are what the next edge samples.
   always @(negedge wr_clk) begin
      bit acc, wr;
      if (!rst_n) begin
         pend.delete();
         ready_ok = 1'b0;
         cnt = 0;
      end
      chk("s_ready", 32'(bus.s_ready), 32'(ready_ok && pend.size() < 2));
      chk("wr_en", 32'(bus.wr_en), 32'(pend.size() > 0 && !bus.full));
      chk("stall", 32'(bus.stall), 32'(pend.size() > 0 && bus.full));
      chk("wr_count", 32'(bus.wr_count), 32'(cnt % 65536));
      chk("wr_count4", 32'(bus4.wr_count), 32'(cnt % 16));
      chk("wr_en4", 32'(bus4.wr_en), 32'(bus.wr_en));
      if (!rst_n) chk("din_rst", 32'(bus.din), 32'h0);
      else if (pend.size() > 0) chk("din", 32'(bus.din), 32'(pend[0]));
      if (rst_n) begin
         acc = bus.s_valid && ready_ok && pend.size() < 2;
         wr = pend.size() > 0 && !bus.full;
         if (wr) begin
            void'(pend.pop_front());
            cnt++;
         end
         if (acc) pend.push_back(bus.s_data);
         ready_ok = 1'b1;
      end
   end
   task automatic step();
      @(posedge wr_clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.s_valid = 1'b0;
      bus.full = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask
   task automatic send_word(input logic [7:0] d);
      bus.s_valid = 1'b1;
      bus.s_data = d;
      step();
      bus.s_valid = 1'b0;
      step();
   endtask
   initial begin
      rst_n = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data = 8'h11;
      bus.full = 1'b0;
      repeat (3) step();
      @(negedge wr_clk);
      chk("rst_outs", {bus.s_ready, bus.wr_en, bus.stall, bus.din, bus.wr_count}, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      @(negedge wr_clk);
      chk("ready_after_rst", 32'(bus.s_ready), 32'h1);
      step();
      bus.s_valid = 1'b0;
      @(negedge wr_clk);
      chk("first_wr_en", 32'(bus.wr_en), 32'h1);
      chk("first_din", 32'(bus.din), 32'h11);
      step();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data = 8'(i);
         step();
      end
      bus.s_valid = 1'b0;
      step();
      @(negedge wr_clk);
      chk("stream_count", 32'(bus.wr_count), 32'd16);
      step();
      bus.s_valid = 1'b1;
      bus.s_data = 8'hA0;
      step();
      bus.full = 1'b1;
      bus.s_data = 8'hA1;
      step();
      bus.s_data = 8'hA2;
      @(negedge wr_clk);
      chk("bp_stall", 32'(bus.stall), 32'h1);
      chk("bp_ready", 32'(bus.s_ready), 32'h0);
      repeat (4) step();
      bus.full = 1'b0;
      @(negedge wr_clk);
      chk("bp_a0", {bus.wr_en, bus.din}, 32'h1A0);
      step();
      @(negedge wr_clk);
      chk("bp_a1", {bus.wr_en, bus.din}, 32'h1A1);
      step();
      bus.s_valid = 1'b0;
      @(negedge wr_clk);
      chk("bp_a2", {bus.wr_en, bus.din}, 32'h1A2);
      step();
      do_reset();
      for (int i = 0; i < 15; i++) send_word(8'(i + 1));
      @(negedge wr_clk);
      chk("wrap_15", 32'(bus4.wr_count), 32'hF);
      step();
      send_word(8'h20);
      @(negedge wr_clk);
      chk("wrap_16", 32'(bus4.wr_count), 32'h0);
      step();
      send_word(8'h21);
      @(negedge wr_clk);
      chk("wrap_17", 32'(bus4.wr_count), 32'h1);
      step();
      bus.full = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data = 8'h55;
      step();
      bus.s_data = 8'h66;
      step();
      bus.s_valid = 1'b0;
      bus.full = 1'b0;
      #1;
      chk("two_wr_en", 32'(bus.wr_en), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", 32'(bus.wr_en), 32'h0);
      chk("midrst_ready", 32'(bus.s_ready), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      send_word(8'h77);
      step();
      chk("midrst_count", 32'(bus.wr_count), 32'h1);
      for (int i = 0; i < 10000; i++) begin
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_data = 8'($urandom);
         bus.full = ($urandom_range(0, 3) == 0);
         step();
      end
      bus.s_valid = 1'b0;
      bus.full = 1'b0;
      repeat (4) step();
      chk("drained", 32'(pend.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
